// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   Multi-channel programmable clock divider for the motion clocks. Every
//   channel divides inClk by 2*(div+1) while its motion enable is high,
//   emits a one-cycle tick on every outClk toggle, and has a divisor that
//   can be reloaded or stepped down (floored at MIN_DIV) at runtime.
//
// Ports
//   inClk   in   system clock, all state on posedge
//   reset   in   asynchronous active-high reset, clears all state
//   motion  in   [CHANNELS]        per-channel run enable
//   period  in   [CHANNELS*WIDTH]  per-channel load value, channel i at [i*WIDTH +: WIDTH]
//   load    in   [CHANNELS]        copy period slice into the divisor
//   faster  in   [CHANNELS]        decrease divisor by STEP, floored at MIN_DIV
//   sync    in   synchronous clear of counters and outputs (divisors kept)
//   outClk  out  [CHANNELS]        divided clocks, 50% duty
//   tick    out  [CHANNELS]        one-cycle strobe on each outClk toggle
//   curDiv  out  [CHANNELS*WIDTH]  current divisor per channel
module clock_divider_multi #(
  parameter int unsigned              CHANNELS  = 2,
  parameter int unsigned              WIDTH     = 32,
  parameter logic [WIDTH-1:0]         RESET_DIV = 32'd12_500_000,
  parameter logic [WIDTH-1:0]         MIN_DIV   = 32'd1_000_000,
  parameter logic [WIDTH-1:0]         STEP      = 32'd250_000
) (
  input  logic                        inClk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         motion,
  input  logic [CHANNELS*WIDTH-1:0]   period,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS-1:0]         faster,
  input  logic                        sync,
  output logic [CHANNELS-1:0]         outClk,
  output logic [CHANNELS-1:0]         tick,
  output logic [CHANNELS*WIDTH-1:0]   curDiv
);

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    div_q [CHANNELS];
  logic [WIDTH-1:0]    div_d [CHANNELS];
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] tick_q, tick_d;

  // Speed-up step with saturation at MIN_DIV. The threshold is formed one
  // bit wider so MIN_DIV+STEP cannot wrap when both sit near 2^WIDTH.
  function automatic logic [WIDTH-1:0] sat_speed_up(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] thresh;
    thresh = {1'b0, MIN_DIV} + {1'b0, STEP};
    if ({1'b0, d} >= thresh) sat_speed_up = d - STEP;
    else                     sat_speed_up = MIN_DIV;
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      out_d[i]  = out_q[i];
      tick_d[i] = 1'b0;
      div_d[i]  = div_q[i];

      // Counter: compares against the divisor currently held, so a new
      // divisor is used from the following cycle. The >= wrap keeps the
      // counter bounded even when a smaller divisor is loaded mid-count.
      if (sync) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end else if (!motion[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (cnt_q[i] < div_q[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i]  = '0;
        out_d[i]  = ~out_q[i];
        tick_d[i] = 1'b1;
      end

      // Divisor: load wins over faster; unaffected by motion and sync.
      if (load[i])        div_d[i] = period[i*WIDTH +: WIDTH];
      else if (faster[i]) div_d[i] = sat_speed_up(div_q[i]);
    end
  end

  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= RESET_DIV;
      end
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) curDiv[i*WIDTH +: WIDTH] = div_q[i];
  end

  assign outClk = out_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  localparam int NCH   = 2;
  localparam int W     = 8;
  localparam int RDIV  = 3;
  localparam int MIND  = 4;
  localparam int STEPV = 3;

  logic             inClk;
  logic             reset;
  logic [NCH-1:0]   motion;
  logic [NCH*W-1:0] period;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   faster;
  logic             sync;
  logic [NCH-1:0]   outClk;
  logic [NCH-1:0]   tick;
  logic [NCH*W-1:0] curDiv;

  clock_divider_multi #(
    .CHANNELS (NCH),
    .WIDTH    (W),
    .RESET_DIV(8'd3),
    .MIN_DIV  (8'd4),
    .STEP     (8'd3)
  ) dut (
    .inClk (inClk),
    .reset (reset),
    .motion(motion),
    .period(period),
    .load  (load),
    .faster(faster),
    .sync  (sync),
    .outClk(outClk),
    .tick  (tick),
    .curDiv(curDiv)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  typedef struct {
    int out_v;
    int tick_v;
    int div_v;
  } exp_t;

  exp_t q[$];
  int   nvec  = 0;
  int   nfail = 0;

  // Reference: each channel tracks enabled cycles spent in the current
  // half-period, the output level, the tick, and the divisor.
  int elapsed [NCH];
  int level   [NCH];
  int strobe  [NCH];
  int divisor [NCH];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.out_v = 0; e.tick_v = 0; e.div_v = 0;
    for (int c = 0; c < NCH; c++) begin
      e.out_v  |= level[c]  << c;
      e.tick_v |= strobe[c] << c;
      e.div_v  |= divisor[c] << (c*W);
    end
    return e;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      elapsed[c] = 0; level[c] = 0; strobe[c] = 0; divisor[c] = RDIV;
    end
  endfunction

  // Drive one cycle of inputs (called at a negedge), predict the state after
  // the next posedge, then advance to the following negedge.
  task automatic step(input logic [NCH-1:0] mo, input logic [NCH-1:0] ld,
                      input logic [NCH-1:0] fa, input logic sy,
                      input int p0, input int p1);
    int p [NCH];
    p[0] = p0 & 255; p[1] = p1 & 255;
    motion = mo; load = ld; faster = fa; sync = sy;
    period = {p[1][W-1:0], p[0][W-1:0]};
    for (int c = 0; c < NCH; c++) begin
      int half = divisor[c] + 1;  // enabled cycles per half-period
      if (sy) begin
        elapsed[c] = 0; level[c] = 0; strobe[c] = 0;
      end else if (!mo[c]) begin
        strobe[c] = 0;
      end else if (elapsed[c] + 1 >= half) begin
        elapsed[c] = 0; level[c] = 1 - level[c]; strobe[c] = 1;
      end else begin
        elapsed[c] = elapsed[c] + 1; strobe[c] = 0;
      end
      if (ld[c])      divisor[c] = p[c];
      else if (fa[c]) divisor[c] = (divisor[c] - STEPV < MIND) ? MIND : divisor[c] - STEPV;
    end
    q.push_back(snapshot());
    @(negedge inClk);
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] mo);
    for (int k = 0; k < n; k++) step(mo, 2'b00, 2'b00, 1'b0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    @(posedge inClk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_outClk", int'(outClk), 0);
    chk("rst_tick",   int'(tick),   0);
    chk("rst_curDiv", int'(curDiv), (RDIV << W) | RDIV);
    model_reset();
    motion = '0; load = '0; faster = '0; sync = 1'b0; period = '0;
    @(negedge inClk);
    reset = 1'b0;
  endtask

  // Monitor: outputs are registered and present every cycle; compare each
  // one against the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge inClk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("outClk", int'(outClk), e.out_v);
        chk("tick",   int'(tick),   e.tick_v);
        chk("curDiv", int'(curDiv), e.div_v);
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    motion = '0; load = '0; faster = '0; sync = 1'b0; period = '0;
    model_reset();
    @(negedge inClk);
    @(negedge inClk);
    chk("init_outClk", int'(outClk), 0);
    chk("init_tick",   int'(tick),   0);
    chk("init_curDiv", int'(curDiv), (RDIV << W) | RDIV);
    reset = 1'b0;

    // Reset divisor 3 on channel 0: toggles at cycles 4, 8, 12.
    idle(13, 2'b01);

    // Load 5, run, freeze mid-count, resume.
    step(2'b00, 2'b01, 2'b00, 1'b1, 5, 0);
    idle(8, 2'b01);
    idle(10, 2'b00);
    idle(10, 2'b01);

    // Speed-up on channel 1 from 12: 9, 6, 4, 4.
    step(2'b00, 2'b10, 2'b00, 1'b0, 0, 12);
    for (int k = 0; k < 4; k++) step(2'b10, 2'b00, 2'b10, 1'b0, 0, 0);

    // Load beats faster.
    step(2'b11, 2'b11, 2'b11, 1'b0, 20, 20);

    // Counter well past a newly loaded smaller divisor.
    step(2'b00, 2'b00, 2'b00, 1'b1, 0, 0);
    idle(9, 2'b11);
    step(2'b11, 2'b01, 2'b00, 1'b0, 3, 0);
    idle(10, 2'b11);

    // Divisor 0: continuous tick.
    step(2'b11, 2'b10, 2'b00, 1'b0, 0, 0);
    idle(5, 2'b11);

    // Sync with mixed phases.
    step(2'b11, 2'b11, 2'b00, 1'b0, 2, 5);
    idle(7, 2'b11);
    step(2'b11, 2'b00, 2'b00, 1'b1, 0, 0);
    idle(4, 2'b11);

    // Async reset mid-count.
    async_reset();
    idle(6, 2'b11);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] mo, ld, fa;
      logic sy;
      int p0, p1;
      for (int c = 0; c < NCH; c++) begin
        mo[c] = ($urandom_range(0, 3) != 0);
        ld[c] = ($urandom_range(0, 15) == 0);
        fa[c] = ($urandom_range(0, 9) == 0);
      end
      sy = ($urandom_range(0, 63) == 0);
      p0 = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
      p1 = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
      step(mo, ld, fa, sy, p0, p1);
      if (n % 700 == 699) async_reset();
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge inClk);
      guard++;
    end
    if (q.size() > 0) chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised, multi-channel successor to the ball clock divider. Each channel divides `inClk` down by a runtime-programmable half-period, gated by its own motion enable. Channels add a one-cycle tick strobe, a per-channel speed-up step for rally acceleration, and a global phase-sync clear. It sits between the game FSM and the ball/paddle position logic, and one instance drives all motion clocks.

## Interface
- `CHANNELS`, default 2: number of independent divider channels (ball X/Y, paddles, ...).
- `WIDTH`, default 32: counter and divisor width in bits.
- `RESET_DIV`, default 32'd12_500_000: divisor loaded into every channel at reset.
- `MIN_DIV`, default 32'd1_000_000: floor for speed-up; never undershot.
- `STEP`, default 32'd250_000: divisor decrement per speed-up pulse.

- `inClk` input 1: system clock; all state on posedge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `motion` input CHANNELS: per-channel run enable; low freezes that channel.
- `period` input CHANNELS*WIDTH: per-channel base divisor, packed, with channel i at [i*WIDTH +: WIDTH].
- `load` input CHANNELS: per-channel pulse; copies `period` slice into divisor.
- `faster` input CHANNELS: per-channel pulse; reduces divisor by STEP, floored at MIN_DIV.
- `sync` input 1: synchronous clear of all counters and outputs; divisors kept.
- `outClk` output CHANNELS: per-channel divided clock, 50% duty.
- `tick` output CHANNELS: one-`inClk` strobe on every `outClk` toggle.
- `curDiv` output CHANNELS*WIDTH: current divisor per channel, packed as `period`.

## Operation
- Per-channel state: `cnt` (WIDTH), `div` (WIDTH), `out`, `tick`. All outputs are registered.
- Counter update per channel, in priority order:
  - `sync`=1: `cnt`<=0, `out`<=0, `tick`<=0.
  - `motion[i]`=0: `cnt` and `out` hold, `tick`<=0.
  - `cnt` < `div`: `cnt`<=`cnt`+1, `tick`<=0.
  - Otherwise (`cnt` >= `div`): `cnt`<=0, `out`<=~`out`, `tick`<=1.
- Divisor update per channel, independent of `motion` and `sync`, in priority order:
  - `load[i]`: `div`<=`period` slice. Values below MIN_DIV are accepted as-is.
  - `faster[i]`: if `div` >= MIN_DIV+STEP, then `div`<=`div`-STEP; else `div`<=MIN_DIV. Compute the compare in WIDTH+1 bits so no overflow occurs.
  - Otherwise hold.
- A divisor change takes effect on the next compare. If `cnt` > new `div`, the channel wraps on the next enabled cycle. The counter never runs past `div`+1 and never wraps through 2^WIDTH.
- `div`=0 means `out` toggles every enabled cycle and `tick` is held high continuously.
- Channels are fully independent apart from `sync` and `reset`.

## Timing
- Reset (async assert, released synchronously by the system): `cnt`=0, `out`=0, `tick`=0, `div`=RESET_DIV. So `outClk`=0, `tick`=0, `curDiv`=RESET_DIV for all channels.
- Reset asserted mid-count clears immediately, with no partial tick.
- Half-period of `outClk` is `div`+1 enabled cycles. Full period is 2·(`div`+1).
- `tick[i]` is high in the same cycle that `outClk[i]` changes, for exactly one cycle per toggle.
- The first toggle after reset or `sync` with `motion` high occurs `div`+1 cycles after `motion` is first sampled high.
- `load`/`faster` latency: `curDiv` updates on the edge that samples the pulse (visible the next cycle). A pulse held for k cycles applies k times for `faster`.
- Dropping `motion` freezes `cnt` and `out` exactly; restoring it resumes counting from the frozen value.

## Test plan
- Reset with `period` ignored, `motion`=1 on channel 0 (RESET_DIV overridden to 3) -> `outClk[0]` toggles at cycles 4, 8, 12, …; `tick[0]` is high one cycle at each toggle; `curDiv`=3.
- `load` with `period`=5, then `motion` high -> half-period of 6 cycles; drop `motion` at `cnt`=2 for 10 cycles -> no toggle, and the next toggle comes 4 cycles after re-enable.
- MIN_DIV=4, STEP=3, `div`=12: `faster` ×4 -> `curDiv` sequence 9, 6, 4, 4.
- `load` and `faster` in the same cycle with `period`=20 -> `curDiv`=20.
- `cnt`=9, `div` changed to 3 by `load` -> wrap and toggle on the next enabled cycle, then half-period of 4.
- `sync` pulse with channels at mixed phases -> all `outClk`=0 and `cnt`=0 the next cycle, `curDiv` unchanged; async `reset` mid-count -> outputs cleared without waiting for a clock edge.
